// File: rtl/move_sequencer_pkg.sv
// Shared constants, state encodings and index helpers for the 3x3 tile-merge sequencer.
package move_sequencer_pkg;

  localparam int unsigned TILE_W  = 3;
  localparam int unsigned BOARD_N = 3;
  localparam int unsigned CELLS   = BOARD_N * BOARD_N;
  localparam int unsigned BOARD_W = CELLS * TILE_W;
  localparam int unsigned LINE_W  = BOARD_N * TILE_W;

  localparam logic [TILE_W-1:0] WIN_TILE  = 3'd7;
  localparam logic [15:0]       LFSR_MASK = 16'hB400;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MERGE = 3'd1;
  localparam logic [2:0] S_SPAWN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WON   = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    MERGE = S_MERGE,
    SPAWN = S_SPAWN,
    CHECK = S_CHECK,
    OVER  = S_OVER,
    WON   = S_WON
  } state_e;

  // Board cell index (r*3+c) of element k of line 'line' for a given direction.
  function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] line,
                                          input logic [1:0] k);
    logic [1:0] r;
    logic [1:0] c;
    case (dir)
      DIR_LEFT:  begin r = line;      c = k;         end
      DIR_RIGHT: begin r = line;      c = 2'd2 - k;  end
      DIR_UP:    begin r = k;         c = line;      end
      default:   begin r = 2'd2 - k;  c = line;      end
    endcase
    return {2'b00, r} * 4'd3 + {2'b00, c};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ({1'b0, s[15:1]} ^ LFSR_MASK) : {1'b0, s[15:1]};
  endfunction

endpackage

// File: rtl/move_sequencer_row_ops.sv
// Single-line slide-and-merge: compacts tiles toward element 0, merges equal pairs once.
module row_ops
  import move_sequencer_pkg::*;
(
  input  logic [LINE_W-1:0] line_in,
  output logic [LINE_W-1:0] line_out
);

  logic [TILE_W-1:0] a [BOARD_N];
  logic [TILE_W-1:0] c [BOARD_N];
  logic [TILE_W-1:0] o [BOARD_N];
  int unsigned       n;

  always_comb begin
    n = 0;
    for (int unsigned k = 0; k < BOARD_N; k++) begin
      a[k] = line_in[k*TILE_W +: TILE_W];
      c[k] = '0;
    end
    for (int unsigned k = 0; k < BOARD_N; k++) begin
      if (a[k] != '0) begin
        c[n[1:0]] = a[k];
        n = n + 1;
      end
    end

    // Pair nearest element 0 wins; a merged tile never merges again.
    o[0] = c[0];
    o[1] = c[1];
    o[2] = c[2];
    if (c[0] != '0 && c[0] == c[1]) begin
      o[0] = c[0] + 3'd1;
      o[1] = c[2];
      o[2] = '0;
    end else if (c[1] != '0 && c[1] == c[2]) begin
      o[1] = c[1] + 3'd1;
      o[2] = '0;
    end

    line_out = {o[2], o[1], o[0]};
  end

endmodule

// File: rtl/move_sequencer.sv
// 3x3 tile-merge game sequencer: accepts moves, merges one line per cycle, spawns tiles
// from a Galois LFSR and flags win / game-over.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_game,
  input  logic                load_valid,
  input  logic [BOARD_W-1:0]  load_board,
  input  logic                move_valid,
  input  logic [1:0]          move_dir,
  output logic                move_ready,
  output logic [BOARD_W-1:0]  board,
  output logic                busy,
  output logic                done,
  output logic                moved,
  output logic                game_over,
  output logic                win
);

  state_e             state;
  logic [15:0]        lfsr;
  logic [1:0]         line_idx;
  logic [1:0]         dir_q;
  logic [BOARD_W-1:0] snapshot;
  logic               changed;
  logic               spawn_two;

  logic [LINE_W-1:0]  line_in;
  logic [LINE_W-1:0]  line_out;
  logic [BOARD_W-1:0] merged_board;
  logic [BOARD_W-1:0] spawn_board;
  logic               has_win;
  logic               has_empty;
  logic               has_pair;

  assign move_ready = (state == IDLE);
  assign busy       = !(state == IDLE || state == OVER || state == WON);

  always_comb begin : gather
    logic [3:0] idx;
    idx     = '0;
    line_in = '0;
    for (int unsigned k = 0; k < BOARD_N; k++) begin
      idx = cell_idx(dir_q, line_idx, 2'(k));
      line_in[k*TILE_W +: TILE_W] = board[idx*TILE_W +: TILE_W];
    end
  end

  row_ops u_row_ops (
    .line_in  (line_in),
    .line_out (line_out)
  );

  always_comb begin : scatter
    logic [3:0] idx;
    idx          = '0;
    merged_board = board;
    for (int unsigned k = 0; k < BOARD_N; k++) begin
      idx = cell_idx(dir_q, line_idx, 2'(k));
      merged_board[idx*TILE_W +: TILE_W] = line_out[k*TILE_W +: TILE_W];
    end
  end

  always_comb begin : spawn
    logic [3:0]        cand;
    logic [4:0]        pos;
    logic [TILE_W-1:0] val;
    logic              found;
    spawn_board = board;
    found       = 1'b0;
    cand        = lfsr[3:0] % 4'd9;
    val         = (lfsr[7:4] == 4'd0) ? 3'd2 : 3'd1;
    pos         = '0;
    // Upward scan from the candidate with wrap 8->0; 5-bit sum avoids overflow.
    for (int unsigned k = 0; k < CELLS; k++) begin
      pos = {1'b0, cand} + 5'(k);
      if (pos >= 5'd9) pos = pos - 5'd9;
      if (!found && board[pos*TILE_W +: TILE_W] == '0) begin
        spawn_board[pos*TILE_W +: TILE_W] = val;
        found = 1'b1;
      end
    end
  end

  always_comb begin : status
    logic [TILE_W-1:0] v;
    has_win   = 1'b0;
    has_empty = 1'b0;
    has_pair  = 1'b0;
    v         = '0;
    for (int unsigned r = 0; r < BOARD_N; r++) begin
      for (int unsigned c = 0; c < BOARD_N; c++) begin
        v = board[(r*BOARD_N + c)*TILE_W +: TILE_W];
        if (v == WIN_TILE) has_win = 1'b1;
        if (v == '0) has_empty = 1'b1;
        if (c < BOARD_N-1 && v == board[(r*BOARD_N + c + 1)*TILE_W +: TILE_W]) has_pair = 1'b1;
        if (r < BOARD_N-1 && v == board[((r+1)*BOARD_N + c)*TILE_W +: TILE_W]) has_pair = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      board     <= '0;
      lfsr      <= LFSR_SEED;
      line_idx  <= '0;
      dir_q     <= DIR_UP;
      snapshot  <= '0;
      changed   <= 1'b0;
      spawn_two <= 1'b0;
      done      <= 1'b0;
      moved     <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      done <= 1'b0;
      if (new_game) begin
        board     <= '0;
        game_over <= 1'b0;
        win       <= 1'b0;
        line_idx  <= '0;
        changed   <= 1'b1;
        spawn_two <= 1'b1;
        state     <= SPAWN;
      end else begin
        case (state)
          IDLE, OVER, WON: begin
            if (load_valid) begin
              board     <= load_board;
              game_over <= 1'b0;
              win       <= 1'b0;
              changed   <= 1'b0;
              state     <= CHECK;
            end else if (move_valid && state == IDLE) begin
              snapshot <= board;
              dir_q    <= move_dir;
              line_idx <= '0;
              state    <= MERGE;
            end
          end
          MERGE: begin
            board <= merged_board;
            if (line_idx == 2'd2) begin
              line_idx  <= '0;
              changed   <= (merged_board != snapshot);
              spawn_two <= 1'b0;
              state     <= (merged_board != snapshot) ? SPAWN : CHECK;
            end else begin
              line_idx <= line_idx + 2'd1;
            end
          end
          SPAWN: begin
            board <= spawn_board;
            if (spawn_two) spawn_two <= 1'b0;
            else           state     <= CHECK;
          end
          CHECK: begin
            done  <= 1'b1;
            moved <= changed;
            if (has_win) begin
              win   <= 1'b1;
              state <= WON;
            end else if (!has_empty && !has_pair) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
